// File: rtl/tdm_demux4_if.sv
// Bus bundle for the 4-slot TDM demultiplexer: sample stream in, frame and status out.
interface tdm_demux4_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             frame_valid;
  logic             s1;
  logic             s0;
  logic             locked;
  logic             sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  a, b, c, d, frame_valid, s1, s0, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output a, b, c, d, frame_valid, s1, s0, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: hunts for frame_sync, collects a frame into shadow
// registers and publishes all four slots together on frame completion.
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux4_if.slave   bus
);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_r, state_nxt_s;
  logic [1:0]       slot_r, slot_nxt_s;
  logic [WIDTH-1:0] sh0_r, sh1_r, sh2_r;
  logic [WIDTH-1:0] sh0_nxt_s, sh1_nxt_s, sh2_nxt_s;
  logic [WIDTH-1:0] a_r, b_r, c_r, d_r;
  logic [WIDTH-1:0] a_nxt_s, b_nxt_s, c_nxt_s, d_nxt_s;
  logic             fv_r, fv_nxt_s;
  logic             se_r, se_nxt_s;
  logic             locked_r;

  // Next-state, shadow capture and frame publish decisions for each beat.
  always_comb begin
    state_nxt_s = state_r;
    slot_nxt_s  = slot_r;
    sh0_nxt_s   = sh0_r;
    sh1_nxt_s   = sh1_r;
    sh2_nxt_s   = sh2_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    c_nxt_s     = c_r;
    d_nxt_s     = d_r;
    fv_nxt_s    = 1'b0;
    se_nxt_s    = 1'b0;
    if (bus.din_valid) begin
      case (state_r)
        HUNT: begin
          if (bus.frame_sync) begin
            sh0_nxt_s   = bus.din;
            slot_nxt_s  = 2'd1;
            state_nxt_s = LOCKED;
          end else begin
            slot_nxt_s  = 2'd0;
          end
        end
        LOCKED: begin
          if (bus.frame_sync) begin
            // A sync mid-frame restarts the frame; the stale partial is simply overwritten.
            sh0_nxt_s  = bus.din;
            slot_nxt_s = 2'd1;
            se_nxt_s   = (slot_r != 2'd0);
          end else if (slot_r == 2'd0) begin
            se_nxt_s    = 1'b1;
            slot_nxt_s  = 2'd0;
            state_nxt_s = HUNT;
          end else if (slot_r == 2'd3) begin
            a_nxt_s    = sh0_r;
            b_nxt_s    = sh1_r;
            c_nxt_s    = sh2_r;
            d_nxt_s    = bus.din;
            slot_nxt_s = 2'd0;
            fv_nxt_s   = 1'b1;
          end else begin
            case (slot_r)
              2'd1:    sh1_nxt_s = bus.din;
              2'd2:    sh2_nxt_s = bus.din;
              default: sh0_nxt_s = sh0_r;
            endcase
            slot_nxt_s = slot_r + 2'd1;
          end
        end
        default: begin
          state_nxt_s = HUNT;
          slot_nxt_s  = 2'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, shadow and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= HUNT;
      slot_r   <= 2'd0;
      sh0_r    <= '0;
      sh1_r    <= '0;
      sh2_r    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      c_r      <= '0;
      d_r      <= '0;
      fv_r     <= 1'b0;
      se_r     <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      slot_r   <= slot_nxt_s;
      sh0_r    <= sh0_nxt_s;
      sh1_r    <= sh1_nxt_s;
      sh2_r    <= sh2_nxt_s;
      a_r      <= a_nxt_s;
      b_r      <= b_nxt_s;
      c_r      <= c_nxt_s;
      d_r      <= d_nxt_s;
      fv_r     <= fv_nxt_s;
      se_r     <= se_nxt_s;
      locked_r <= (state_nxt_s == LOCKED);
    end
  end

  assign bus.a           = a_r;
  assign bus.b           = b_r;
  assign bus.c           = c_r;
  assign bus.d           = d_r;
  assign bus.frame_valid = fv_r;
  assign bus.sync_err    = se_r;
  assign bus.locked      = locked_r;
  assign bus.s1          = slot_r[1];
  assign bus.s0          = slot_r[0];

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed and randomized bench for tdm_demux4 against a queue-based frame model.
module tb_tdm_demux4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  tdm_demux4_if #(.WIDTH(8)) bus ();

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the partial frame is a queue whose length is the slot index.
  logic [7:0] m_q[$];
  logic [7:0] m_out[4];
  bit         m_locked;
  bit         m_fv;
  bit         m_se;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
    m_locked = 1'b0;
    m_fv     = 1'b0;
    m_se     = 1'b0;
  endtask

  task automatic model_beat(input bit v, input bit s, input logic [7:0] x);
    m_fv = 1'b0;
    m_se = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_q      = '{x};
          m_locked = 1'b1;
        end
      end else if (s) begin
        m_se = (m_q.size() != 0);
        m_q  = '{x};
      end else if (m_q.size() == 0) begin
        m_se     = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_q.push_back(x);
        if (m_q.size() == 4) begin
          for (int i = 0; i < 4; i++) m_out[i] = m_q[i];
          m_fv = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_a"}, 32'(bus.a), 32'(m_out[0]));
    chk({tag, "_b"}, 32'(bus.b), 32'(m_out[1]));
    chk({tag, "_c"}, 32'(bus.c), 32'(m_out[2]));
    chk({tag, "_d"}, 32'(bus.d), 32'(m_out[3]));
    chk({tag, "_fv"}, 32'(bus.frame_valid), 32'(m_fv));
    chk({tag, "_se"}, 32'(bus.sync_err), 32'(m_se));
    chk({tag, "_locked"}, 32'(bus.locked), 32'(m_locked));
    chk({tag, "_slot"}, 32'({bus.s1, bus.s0}), m_locked ? 32'(m_q.size()) : 32'd0);
    chk({tag, "_excl"}, 32'(bus.frame_valid & bus.sync_err), 32'd0);
  endtask

  task automatic step(input bit v, input bit s, input logic [7:0] x, input string tag);
    @(negedge clk);
    bus.din_valid  = v;
    bus.frame_sync = s;
    bus.din        = x;
    @(posedge clk);
    #1;
    model_beat(v, s, x);
    check_model(tag);
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_abcd"}, {bus.a, bus.b, bus.c, bus.d}, 32'd0);
    chk({tag, "_flags"}, 32'({bus.frame_valid, bus.sync_err, bus.locked, bus.s1, bus.s0}), 32'd0);
  endtask

  // Async reset asserted between edges; outputs must clear before the next clk edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic frame4(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                        input logic [7:0] w3, input int gap, input string tag);
    step(1'b1, 1'b1, w0, tag);
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'h00, tag);
    step(1'b1, 1'b0, w1, tag);
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'h00, tag);
    step(1'b1, 1'b0, w2, tag);
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'h00, tag);
    step(1'b1, 1'b0, w3, tag);
  endtask

  int fv_count;

  initial begin
    checks   = 0;
    failures = 0;
    fv_count = 0;
    rst_n          = 1'b0;
    bus.din        = 8'h00;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    model_reset();
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame at full rate.
    frame4(8'h11, 8'h22, 8'h33, 8'h44, 0, "basic");
    chk("basic_abcd", {bus.a, bus.b, bus.c, bus.d}, 32'h11223344);
    chk("basic_fv", 32'(bus.frame_valid), 32'd1);
    chk("basic_lock_slot", 32'({bus.locked, bus.s1, bus.s0}), 32'b100);
    step(1'b0, 1'b0, 8'h00, "basic_idle");
    chk("basic_fv_one", 32'(bus.frame_valid), 32'd0);

    // Unsynced beats in HUNT are dropped silently; sync with din_valid=0 is ignored.
    async_reset("rst2");
    step(1'b1, 1'b0, 8'h55, "hunt_drop");
    step(1'b1, 1'b0, 8'h66, "hunt_drop");
    step(1'b0, 1'b1, 8'h99, "hunt_novalid");
    chk("hunt_locked", 32'(bus.locked), 32'd0);
    frame4(8'h11, 8'h22, 8'h33, 8'h44, 0, "hunt_frame");
    chk("hunt_abcd", {bus.a, bus.b, bus.c, bus.d}, 32'h11223344);

    // Resync mid-frame discards the partial frame.
    step(1'b1, 1'b1, 8'hA0, "resync");
    step(1'b1, 1'b0, 8'hA1, "resync");
    step(1'b1, 1'b1, 8'hB0, "resync_b0");
    chk("resync_err", 32'(bus.sync_err), 32'd1);
    step(1'b1, 1'b0, 8'hB1, "resync");
    step(1'b1, 1'b0, 8'hB2, "resync");
    step(1'b1, 1'b0, 8'hB3, "resync");
    chk("resync_abcd", {bus.a, bus.b, bus.c, bus.d}, 32'hB0B1B2B3);

    // Missing sync at slot 0 drops lock.
    step(1'b1, 1'b0, 8'h77, "nosync");
    chk("nosync_err_lock", 32'({bus.sync_err, bus.locked}), 32'b10);
    chk("nosync_abcd", {bus.a, bus.b, bus.c, bus.d}, 32'hB0B1B2B3);

    // Gapped frame followed by a full-rate frame.
    frame4(8'h11, 8'h22, 8'h33, 8'h44, 3, "gap");
    if (bus.frame_valid) fv_count++;
    frame4(8'h01, 8'h02, 8'h03, 8'h04, 0, "b2b");
    if (bus.frame_valid) fv_count++;
    chk("b2b_fv_count", 32'(fv_count), 32'd2);
    chk("b2b_abcd", {bus.a, bus.b, bus.c, bus.d}, 32'h01020304);

    // Reset mid-frame, then a fresh frame.
    step(1'b1, 1'b1, 8'hC0, "midrst");
    step(1'b1, 1'b0, 8'hC1, "midrst");
    async_reset("midrst_zero");
    frame4(8'hD0, 8'hD1, 8'hD2, 8'hD3, 0, "after_rst");
    chk("after_rst_abcd", {bus.a, bus.b, bus.c, bus.d}, 32'hD0D1D2D3);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           8'($urandom_range(0, 255)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter WIDTH, default 8, sets the sample width of din and of each of a, b, c and d.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 din  input  WIDTH  TDM sample stream.
REQ-005 din_valid  input  1  din carries a sample this cycle.
REQ-006 frame_sync  input  1  qualified by din_valid; marks the slot-0 sample of a frame.
REQ-007 a, b, c, d  output  WIDTH  each holds the last complete frame, slots 0 to 3 respectively.
REQ-008 frame_valid  output  1  one-cycle pulse that fires when a, b, c and d update together.
REQ-009 s1, s0  output  1 each  current slot index {s1,s0}; the next accepted sample goes to that slot.
REQ-010 locked  output  1  high while the FSM is in LOCKED.
REQ-011 sync_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-012 The block SHALL implement a two-state FSM with states HUNT and LOCKED; locked = (state == LOCKED).
REQ-013 A beat SHALL be defined as a rising clk edge with din_valid=1; frame_sync with din_valid=0 SHALL be ignored.
REQ-014 When no beat occurs, state, slot, shadow registers and a, b, c and d SHALL hold.
REQ-015 In HUNT, a beat with frame_sync=0 SHALL be dropped with no state change and no sync_err.
REQ-016 In HUNT, a beat with frame_sync=1 SHALL:
- store din in shadow slot 0;
- set slot to 1;
- move the FSM to LOCKED.
REQ-017 In LOCKED, a beat with slot=0 and frame_sync=1 SHALL store din in shadow slot 0 and set slot to 1.
REQ-018 In LOCKED, a beat with slot in 1..2 and frame_sync=0 SHALL store din in shadow[slot] and increment slot.
REQ-019 In LOCKED, a beat with slot=3 and frame_sync=0 SHALL, on that same edge:
- load a, b, c and d from shadow slots 0, 1, 2 and din;
- wrap slot to 0;
- drive frame_valid=1 for exactly the following cycle.
REQ-020 Outputs a, b, c and d SHALL change only on frame completion; a partial frame SHALL never reach them.
REQ-021 In LOCKED, a beat with frame_sync=1 and slot≠0 SHALL:
- pulse sync_err for one cycle;
- discard the partial frame;
- store din in shadow slot 0 and set slot to 1;
- remain in LOCKED.
REQ-022 In LOCKED, a beat with slot=0 and frame_sync=0 SHALL:
- pulse sync_err for one cycle;
- drop the sample;
- set slot to 0 and move the FSM to HUNT.
REQ-023 A frame SHALL complete over any number of cycles; idle gaps (din_valid=0) between beats SHALL be legal.
REQ-024 Back-to-back frames at one beat per cycle SHALL be sustained with no lost samples.
REQ-025 frame_valid and sync_err SHALL never assert in the same cycle.
REQ-026 All outputs SHALL be driven directly from registers.

Reset
REQ-027 While rst_n=0, the block SHALL immediately and asynchronously force:
- FSM to HUNT, slot to 0;
- shadow registers and a, b, c and d to 0;
- frame_valid, sync_err, locked, s1 and s0 to 0.
REQ-028 A reset asserted mid-frame SHALL discard the partial frame; a, b, c and d SHALL read 0 after reset.
REQ-029 The first beat after rst_n deasserts SHALL be processed under the HUNT rules.

Verification
REQ-030 Reset, then one beat per cycle 0x11(sync), 0x22, 0x33, 0x44 -> after the fourth edge a=0x11, b=0x22, c=0x33, d=0x44; frame_valid high for one cycle; locked=1; {s1,s0}=0.
REQ-031 From reset, beats 0x55 and 0x66 with frame_sync=0, then the REQ-030 frame -> 0x55 and 0x66 dropped; no sync_err; outputs as in REQ-030.
REQ-032 While locked, beats 0xA0(sync), 0xA1, then 0xB0(sync), 0xB1, 0xB2, 0xB3 -> sync_err pulses on the 0xB0 beat; then a=0xB0, b=0xB1, c=0xB2, d=0xB3 with one frame_valid pulse; 0xA0 and 0xA1 never appear on the outputs.
REQ-033 While locked at slot 0, a beat of 0x77 with frame_sync=0 -> sync_err pulse; locked=0; a, b, c and d unchanged.
REQ-034 REQ-030 frame sent with 3 idle cycles between beats, immediately followed by 0x01(sync), 0x02, 0x03, 0x04 at full rate -> two frame_valid pulses; final outputs 0x01, 0x02, 0x03, 0x04.
REQ-035 rst_n pulled low after two beats of a frame -> all outputs 0 immediately, before the next clk edge; the next sync beat starts a fresh frame.
